// File: rtl/cordic_vec.sv
// Iterative CORDIC vectoring unit: converts (xin, yin) to an angle in degrees
// and a gain-corrected magnitude, one micro-rotation per enabled cycle.
module cordic_vec #(
  parameter int wi = 16,
  parameter int wf = 16,
  parameter int N  = 10
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic                     start,
  input  logic signed [wi+wf-1:0]  xin,
  input  logic signed [wi+wf-1:0]  yin,
  output logic                     busy,
  output logic                     done,
  output logic signed [31:0]       angout,
  output logic signed [31:0]       mag
);

  localparam int W = wi + wf;
  localparam logic signed [21:0] Z_P90  = 22'sd184320;
  localparam logic signed [21:0] Z_N90  = -22'sd184320;
  localparam logic signed [20:0] K_GAIN = 21'sd636751;

  typedef enum logic [1:0] {IDLE, ITER, SCALE, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic signed [23:0] x_q, x_d, y_q, y_d;
  logic signed [21:0] z_q, z_d, ang_q, ang_d;
  logic signed [23:0] mag_q, mag_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;

  // Operand bits [wf+1:wf-20] as a Q(4,20) value.
  function automatic logic signed [23:0] capture(input logic signed [W-1:0] v);
    logic signed [W+19:0] ext;
    logic signed [21:0]   t;
    ext = {v, 20'b0};
    t   = 22'(ext >>> wf);
    return 24'(t);
  endfunction

  function automatic logic signed [21:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    return 22'sd92160;
      4'd1:    return 22'sd54405;
      4'd2:    return 22'sd28746;
      4'd3:    return 22'sd14592;
      4'd4:    return 22'sd7324;
      4'd5:    return 22'sd3666;
      4'd6:    return 22'sd1833;
      4'd7:    return 22'sd917;
      4'd8:    return 22'sd458;
      4'd9:    return 22'sd229;
      4'd10:   return 22'sd115;
      4'd11:   return 22'sd57;
      4'd12:   return 22'sd29;
      4'd13:   return 22'sd14;
      4'd14:   return 22'sd7;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    logic signed [23:0] xc, yc;
    logic signed [44:0] prod;
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    ang_d   = ang_q;
    mag_d   = mag_q;
    zero_d  = zero_q;
    done_d  = (state_q == DONE);
    xc      = capture(xin);
    yc      = capture(yin);
    prod    = 45'(x_q) * 45'(K_GAIN);
    case (state_q)
      IDLE: begin
        // The done pulse lands one cycle after DONE; that cycle still counts as busy.
        if (start && !done_q) begin
          zero_d  = (xin == '0) && (yin == '0);
          cnt_d   = '0;
          state_d = ITER;
          if (!xc[23]) begin
            x_d = xc;  y_d = yc;  z_d = '0;
          end else if (!yc[23]) begin
            x_d = yc;  y_d = -xc; z_d = Z_P90;
          end else begin
            x_d = -yc; y_d = xc;  z_d = Z_N90;
          end
        end
      end
      ITER: begin
        if (EN) begin
          if (!y_q[23]) begin
            x_d = x_q + (y_q >>> cnt_q);
            y_d = y_q - (x_q >>> cnt_q);
            z_d = z_q + atan_lut(cnt_q);
          end else begin
            x_d = x_q - (y_q >>> cnt_q);
            y_d = y_q + (x_q >>> cnt_q);
            z_d = z_q - atan_lut(cnt_q);
          end
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(N - 1)) state_d = SCALE;
        end
      end
      SCALE: begin
        if (EN) begin
          mag_d   = zero_q ? '0 : 24'(prod >>> 20);
          ang_d   = zero_q ? '0 : z_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      ang_q   <= '0;
      mag_q   <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      ang_q   <= ang_d;
      mag_q   <= mag_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  logic signed [31:0] mag_ext;
  assign mag_ext = {{8{mag_q[23]}}, mag_q};
  assign mag     = mag_ext >>> 4;
  assign angout  = {{5{ang_q[21]}}, ang_q, 5'b0};
  assign busy    = (state_q != IDLE) || done_q;
  assign done    = done_q;

endmodule

// File: doc/cordic_vec.md
CORDIC_VEC -- requirements
Module: cordic_vec

Interface
REQ-001 Parameter wi, default 16: integer bits of xin/yin/angout/mag.
REQ-002 Parameter wf, default 16: fractional bits of xin/yin/angout/mag.
REQ-003 Parameter N, default 10: number of CORDIC iterations; legal range 1..15.
REQ-004 CLK  input  1: single clock; all state changes on the rising edge.
REQ-005 RST  input  1: synchronous, active-high reset.
REQ-006 EN  input  1: advance enable; low stalls ITER and SCALE.
REQ-007 start  input  1: request pulse; sampled only in IDLE.
REQ-008 xin  input  wi+wf signed: X operand, Q(wi,wf); legal range [-1.0, 1.0].
REQ-009 yin  input  wi+wf signed: Y operand, Q(wi,wf); legal range [-1.0, 1.0].
REQ-010 busy  output  1: high in ITER, SCALE and DONE.
REQ-011 done  output  1: one-cycle pulse; angout/mag are valid from this cycle onward.
REQ-012 angout  output  32 signed: atan2(yin,xin) in degrees, Q16.16, range (-180, 180].
REQ-013 mag  output  32 signed: sqrt(xin^2+yin^2), gain-corrected, Q16.16, non-negative.

Function
REQ-014 Internal datapath: x,y signed 24-bit Q(4,20); z signed 22-bit Q(11,11) degrees.
REQ-015 Operand capture: xin/yin bits [wf+1:wf-20] sign-extended to 24 bits.
REQ-016 Arctangent table: hard-wired constants round(atan(2^-i)*180/pi*2048), i=0..14 (i=0 -> 92160, i=1 -> 54405, i=2 -> 28746); no file load.
REQ-017 FSM states IDLE, ITER, SCALE, DONE; reset state IDLE.
REQ-018 IDLE: start=1 captures operands, clears count to 0, goes to ITER; start=0 stays in IDLE.
REQ-019 Pre-rotation at capture:
- x>=0: x0=x, y0=y, z0=0.
- x<0, y>=0: x0=y, y0=-x, z0=+90.0.
- x<0, y<0: x0=-y, y0=x, z0=-90.0.
REQ-020 ITER, per cycle with EN=1:
- y>=0: x+=y>>>i, y-=x>>>i, z+=atan_i.
- y<0: x-=y>>>i, y+=x>>>i, z-=atan_i.
- i = count; shifts are arithmetic; both updates use pre-update values; count increments.
REQ-021 ITER exits to SCALE after the iteration with count=N-1.
REQ-022 SCALE (EN=1, one cycle): mag_reg = (x * K) >>> 20, K = round(0.6072529*2^20) = 636751; angle_reg = z; then goes to DONE.
REQ-023 EN=0 in ITER or SCALE holds all state, count and outputs; EN is ignored in IDLE and DONE.
REQ-024 DONE lasts one cycle with done=1, then returns unconditionally to IDLE.
REQ-025 start asserted outside IDLE is ignored and is not queued.
REQ-026 Latency with EN held high: done is high in the cycle following the (N+2)th rising edge after the edge that sampled start (N=10 -> 12 edges).
REQ-027 angout = {5 sign bits of angle_reg, angle_reg, 5'b0}; mag = {8 sign bits of mag_reg[23:0], mag_reg[23:0]} >>> 4.
REQ-028 Zero input: xin=yin=0 at capture forces angle_reg=0 and mag_reg=0 in SCALE, with normal latency.
REQ-029 angout/mag hold their last values until the next SCALE completes.
REQ-030 The x<0, y=0 boundary yields +180.0 (never -180.0).

Reset
REQ-031 RST=1 at any edge forces: IDLE, count=0, x/y/z/angle_reg/mag_reg=0, busy=0, done=0, angout=0, mag=0.
REQ-032 RST overrides start and EN in the same cycle.
REQ-033 Reset mid-operation discards the computation with no done pulse; a start in the first post-reset cycle is accepted.

Verification
REQ-034 xin=1.0, yin=0, EN=1 -> done 12 edges after start; angout=0.0 +/-0.12 deg; mag=1.0 +/-2^-8.
REQ-035 (0,1.0) -> angout 90.0; (-1.0,0) -> +180.0; (0.5,-0.5) -> -45.0, mag 0.7071; (-0.5,-0.5) -> -135.0; all angles +/-0.12 deg, mag +/-2^-8.
REQ-036 start re-pulsed at cycles 3 and 11 of a run -> both ignored; exactly one done; busy continuous until done.
REQ-037 EN low for 5 cycles mid-ITER -> done delayed by exactly 5 cycles; results identical to the unstalled run.
REQ-038 RST pulsed at iteration 4 -> no done; all outputs 0; next start with (0,0) -> angout=0, mag=0 after 12 edges.
